prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Program loader: streams header/payload words into instruction and data memories,
// then releases the core and watches its PC for a halt. Optional watchdog: LOADER_WATCHDOG_EN.
module prog_loader #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 8,
    parameter int HALT_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              im_we,
    output logic              dm_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              core_rst,
    input  logic [DATA_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              err
);
    typedef enum logic [2:0] {HDR, LOAD, RUN, DONE, TOUT, ERR} state_e;

    localparam int HC_W = $clog2(HALT_CYCLES + 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                tgt_dm_q, tgt_dm_d;
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [HC_W-1:0]     eq_cnt_q, eq_cnt_d;
    logic                im_we_q, im_we_d, dm_we_q, dm_we_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d, dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0]   im_wdata_q, im_wdata_d, dm_wdata_q, dm_wdata_d;
    logic                ready_q, ready_d;
    logic                core_rst_q, core_rst_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                xfer;

`ifdef LOADER_WATCHDOG_EN
    localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
    logic                tout_q, tout_d;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // The synchronous reset also gates the handshake so nothing is accepted while it is held.
    assign in_ready = rst && ready_q;
    assign xfer     = in_valid && in_ready;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        tgt_dm_d   = tgt_dm_q;
        pc_d       = pc;
        eq_cnt_d   = '0;
        im_we_d    = 1'b0;
        dm_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        dm_addr_d  = dm_addr_q;
        im_wdata_d = im_wdata_q;
        dm_wdata_d = dm_wdata_q;
`ifdef LOADER_WATCHDOG_EN
        run_cnt_d  = '0;
`endif
        case (state_q)
            HDR: begin
                if (xfer) begin
                    if (in_data[DATA_W-2]) begin
                        state_d = RUN;
                    end else begin
                        tgt_dm_d = in_data[DATA_W-1];
                        addr_d   = in_data[ADDR_W-1:0];
                        state_d  = LOAD;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    if (tgt_dm_q) begin
                        dm_we_d    = 1'b1;
                        dm_addr_d  = addr_q;
                        dm_wdata_d = in_data;
                    end else begin
                        im_we_d    = 1'b1;
                        im_addr_d  = addr_q;
                        im_wdata_d = in_data;
                    end
                    addr_d = addr_q + 1'b1;
                    // Running off the top of memory is fatal rather than wrapping.
                    if (in_last) begin
                        state_d = HDR;
                    end else if (&addr_q) begin
                        state_d = ERR;
                    end
                end
            end
            RUN: begin
                eq_cnt_d = (pc == pc_q) ? eq_cnt_q + 1'b1 : '0;
`ifdef LOADER_WATCHDOG_EN
                run_cnt_d = run_cnt_q + 1'b1;
`endif
                if (eq_cnt_d == HC_W'(HALT_CYCLES)) begin
                    state_d = DONE;
                end
`ifdef LOADER_WATCHDOG_EN
                else if (run_cnt_d == RUN_W'(TIMEOUT_CYCLES)) begin
                    state_d = TOUT;
                end
`endif
            end
            default: begin
            end
        endcase

        // Status flags are decoded from the next state so they change on the same edge.
        ready_d    = (state_d == HDR) || (state_d == LOAD);
        core_rst_d = (state_d != RUN);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
        busy_d     = (state_d == LOAD) || (state_d == RUN) || ((state_d == HDR) && busy_q);
`ifdef LOADER_WATCHDOG_EN
        tout_d     = (state_d == TOUT);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q    <= HDR;
            addr_q     <= '0;
            tgt_dm_q   <= 1'b0;
            pc_q       <= '0;
            eq_cnt_q   <= '0;
            im_we_q    <= 1'b0;
            dm_we_q    <= 1'b0;
            im_addr_q  <= '0;
            dm_addr_q  <= '0;
            im_wdata_q <= '0;
            dm_wdata_q <= '0;
            ready_q    <= 1'b1;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_WATCHDOG_EN
            run_cnt_q  <= '0;
            tout_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tgt_dm_q   <= tgt_dm_d;
            pc_q       <= pc_d;
            eq_cnt_q   <= eq_cnt_d;
            im_we_q    <= im_we_d;
            dm_we_q    <= dm_we_d;
            im_addr_q  <= im_addr_d;
            dm_addr_q  <= dm_addr_d;
            im_wdata_q <= im_wdata_d;
            dm_wdata_q <= dm_wdata_d;
            ready_q    <= ready_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef LOADER_WATCHDOG_EN
            run_cnt_q  <= run_cnt_d;
            tout_q     <= tout_d;
`endif
        end
    end

    assign im_we    = im_we_q;
    assign dm_we    = dm_we_q;
    assign im_addr  = im_addr_q;
    assign dm_addr  = dm_addr_q;
    assign im_wdata = im_wdata_q;
    assign dm_wdata = dm_wdata_q;
    assign core_rst = core_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
`ifdef LOADER_WATCHDOG_EN
    assign timeout  = tout_q;
`else
    assign timeout  = 1'b0;
`endif

endmodule
